// File: rtl/t5_pkg.sv
// Shared opcode, size and state definitions for the T5 data-bus front end.
package t5_pkg;

  localparam logic [4:0] OPC_LOAD  = 5'h00;
  localparam logic [4:0] OPC_STORE = 5'h08;

  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_R = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/t5_dsel.sv
// Lane decoder: byte-lane select, replicated store data and misalign flag
// derived from access size and the low address bits.
module t5_dsel
  import t5_pkg::*;
(
  input  logic [1:0]  size_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [3:0]  sel_o,
  output logic [31:0] dto_o,
  output logic        mis_o
);

  always_comb begin
    sel_o = 4'h0;
    dto_o = dat_i;
    mis_o = 1'b0;
    case (size_i)
      SZ_B: begin
        sel_o = 4'b0001 << adr_i;
        dto_o = {4{dat_i[7:0]}};
      end
      SZ_H: begin
        // adr_i[0] is ignored for lane choice; it only raises the flag
        sel_o = adr_i[1] ? 4'hC : 4'h3;
        dto_o = {2{dat_i[15:0]}};
        mis_o = adr_i[0];
      end
      SZ_W: begin
        sel_o = 4'hF;
        mis_o = |adr_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/t5_front_dwb.sv
// X-stage data-bus front end: two-state bus FSM with registered strobe outputs.
// Optional misalign trap enabled by defining T5_MISALIGN_TRAP_EN (adds port dmis).
module t5_front_dwb
  import t5_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            sclk,
  input  logic            srst_n,
  input  logic [4:0]      xopc,
  input  logic [2:0]      xfn3,
  input  logic [XLEN-1:0] xadr,
  input  logic [XLEN-1:0] xdat,
  input  logic            dwb_ack,
  output logic [XLEN-1:0] dwb_adr,
  output logic [XLEN-1:0] dwb_dto,
  output logic [3:0]      dwb_sel,
  output logic            dwb_wre,
  output logic            dwb_stb,
  output logic [3:0]      xsel,
  output logic            dstall
`ifdef T5_MISALIGN_TRAP_EN
  ,
  output logic            dmis
`endif
);

  state_t state_q, state_d;

  logic [XLEN-1:0] adr_q, dto_q;
  logic [3:0]      sel_q, xsel_q;
  logic            wre_q, stb_q;

  logic [1:0]      size;
  logic            is_mem, req, issue, busy;
  logic [3:0]      sel_c;
  logic [31:0]     dto_c;
  logic            mis_c;
  logic            unused_fn3;

  assign size       = xfn3[1:0];
  assign unused_fn3 = xfn3[2];
  assign is_mem     = ((xopc == OPC_LOAD) || (xopc == OPC_STORE)) && (size != SZ_R);
  assign req        = is_mem && !dstall;

  t5_dsel u_dsel (
    .size_i (size),
    .adr_i  (xadr[1:0]),
    .dat_i  (xdat[31:0]),
    .sel_o  (sel_c),
    .dto_o  (dto_c),
    .mis_o  (mis_c)
  );

`ifdef T5_MISALIGN_TRAP_EN
  logic dmis_q;

  // A trapped request never reaches the bus; it only produces the dmis pulse.
  assign issue = req && !mis_c;
  assign dmis  = dmis_q;

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) dmis_q <= 1'b0;
    else         dmis_q <= req && mis_c;
  end
`else
  logic unused_mis;

  assign issue      = req;
  assign unused_mis = mis_c;
`endif

  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (issue)                 state_d = ST_BUSY;
    else if (busy && dwb_ack)  state_d = ST_IDLE;
  end

  always_comb begin
    busy   = (state_q == ST_BUSY);
    dstall = busy && !dwb_ack;
  end

  // Bus outputs only change on issue or on completion; a stall holds them.
  always_ff @(posedge sclk or negedge srst_n) begin
    if (!srst_n) begin
      adr_q  <= '0;
      dto_q  <= '0;
      sel_q  <= 4'h0;
      xsel_q <= 4'h0;
      wre_q  <= 1'b0;
      stb_q  <= 1'b0;
    end else if (issue) begin
      adr_q  <= {xadr[XLEN-1:2], 2'b00};
      dto_q  <= dto_c;
      sel_q  <= sel_c;
      wre_q  <= (xopc == OPC_STORE);
      stb_q  <= 1'b1;
      if (xopc == OPC_LOAD) xsel_q <= sel_c;
    end else if (busy && dwb_ack) begin
      stb_q  <= 1'b0;
    end
  end

  assign dwb_adr = adr_q;
  assign dwb_dto = dto_q;
  assign dwb_sel = sel_q;
  assign dwb_wre = wre_q;
  assign dwb_stb = stb_q;
  assign xsel    = xsel_q;

endmodule

// File: tb/tb_t5_front_dwb.sv
// Self-checking bench for t5_front_dwb: directed scenarios plus randomized
// traffic against a transaction-level reference model.
module tb_t5_front_dwb;

  logic        sclk;
  logic        srst_n;
  logic [4:0]  xopc;
  logic [2:0]  xfn3;
  logic [31:0] xadr;
  logic [31:0] xdat;
  logic        dwb_ack;
  logic [31:0] dwb_adr;
  logic [31:0] dwb_dto;
  logic [3:0]  dwb_sel;
  logic        dwb_wre;
  logic        dwb_stb;
  logic [3:0]  xsel;
  logic        dstall;
`ifdef T5_MISALIGN_TRAP_EN
  logic        dmis;
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  t5_front_dwb #(.XLEN(32)) dut (
    .sclk    (sclk),
    .srst_n  (srst_n),
    .xopc    (xopc),
    .xfn3    (xfn3),
    .xadr    (xadr),
    .xdat    (xdat),
    .dwb_ack (dwb_ack),
    .dwb_adr (dwb_adr),
    .dwb_dto (dwb_dto),
    .dwb_sel (dwb_sel),
    .dwb_wre (dwb_wre),
    .dwb_stb (dwb_stb),
    .xsel    (xsel),
    .dstall  (dstall)
`ifdef T5_MISALIGN_TRAP_EN
    ,
    .dmis    (dmis)
`endif
  );

  initial sclk = 1'b0;
  always #5 sclk = ~sclk;

  // Reference model: the bus is "in flight" from an accepted request until acked.
  bit          m_busy;
  logic [31:0] m_adr, m_dto;
  logic [3:0]  m_sel, m_xsel;
  bit          m_wre, m_dmis;

  function automatic logic [3:0] ref_sel(input logic [1:0] sz, input logic [1:0] a);
    case (sz)
      2'd0:    return 4'(1 << a);
      2'd1:    return 4'(3 << (a & 2'd2));
      2'd2:    return 4'hF;
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] ref_dto(input logic [1:0] sz, input logic [31:0] d);
    case (sz)
      2'd0:    return (d & 32'hFF) * 32'h01010101;
      2'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  function automatic bit ref_mis(input logic [1:0] sz, input logic [1:0] a);
    return (sz == 2'd1 && (a % 2) == 1) || (sz == 2'd2 && a != 2'd0);
  endfunction

  task automatic model_reset();
    m_busy = 0; m_adr = '0; m_dto = '0; m_sel = '0; m_xsel = '0; m_wre = 0; m_dmis = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied.
  task automatic model_eval();
    bit stalled, mem, accept, trapped;
    stalled = m_busy && !dwb_ack;
    mem     = (xopc == 5'h00 || xopc == 5'h08) && xfn3[1:0] != 2'b11;
    accept  = mem && !stalled;
    trapped = accept && TRAP && ref_mis(xfn3[1:0], xadr[1:0]);
    m_dmis  = trapped;
    if (accept && !trapped) begin
      m_busy = 1;
      m_adr  = xadr & 32'hFFFF_FFFC;
      m_sel  = ref_sel(xfn3[1:0], xadr[1:0]);
      m_dto  = ref_dto(xfn3[1:0], xdat);
      m_wre  = (xopc == 5'h08);
      if (xopc == 5'h00) m_xsel = m_sel;
    end else if (m_busy && dwb_ack) begin
      m_busy = 0;
    end
  endtask

  task automatic drive(input logic [4:0] opc, input logic [2:0] fn3, input logic [31:0] adr,
                       input logic [31:0] dat, input logic ack);
    @(negedge sclk);
    xopc = opc; xfn3 = fn3; xadr = adr; xdat = dat; dwb_ack = ack;
    #1;
  endtask

  task automatic tick();
    model_eval();
    @(posedge sclk);
    #1;
  endtask

  task automatic test_reset();
    srst_n = 1'b0; xopc = 5'h04; xfn3 = 3'b000; xadr = '0; xdat = '0; dwb_ack = 1'b0;
    model_reset();
    #3;
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b exp 0", dwb_stb); end
    checks++; if (dwb_wre !== 1'b0) begin errors++; $display("FAIL reset_wre got %b exp 0", dwb_wre); end
    checks++; if (dstall !== 1'b0) begin errors++; $display("FAIL reset_dstall got %b exp 0", dstall); end
    checks++; if (dwb_adr !== 32'h0) begin errors++; $display("FAIL reset_adr got %h exp 0", dwb_adr); end
    checks++; if (dwb_dto !== 32'h0) begin errors++; $display("FAIL reset_dto got %h exp 0", dwb_dto); end
    checks++; if (dwb_sel !== 4'h0) begin errors++; $display("FAIL reset_sel got %h exp 0", dwb_sel); end
    checks++; if (xsel !== 4'h0) begin errors++; $display("FAIL reset_xsel got %h exp 0", xsel); end
`ifdef T5_MISALIGN_TRAP_EN
    checks++; if (dmis !== 1'b0) begin errors++; $display("FAIL reset_dmis got %b exp 0", dmis); end
`endif
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b0);
    srst_n = 1'b1;
    tick();
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL reset_idle_stb got %b exp 0", dwb_stb); end
    $display("test_reset done");
  endtask

  task automatic test_byte_store();
    drive(5'h08, 3'b000, 32'h1003, 32'h0000_00A5, 1'b0);
    tick();
    checks++; if (dwb_stb !== 1'b1) begin errors++; $display("FAIL bst_stb got %b exp 1", dwb_stb); end
    checks++; if (dwb_adr !== 32'h1000) begin errors++; $display("FAIL bst_adr got %h exp 00001000", dwb_adr); end
    checks++; if (dwb_sel !== 4'h8) begin errors++; $display("FAIL bst_sel got %h exp 8", dwb_sel); end
    checks++; if (dwb_dto !== 32'hA5A5A5A5) begin errors++; $display("FAIL bst_dto got %h exp a5a5a5a5", dwb_dto); end
    checks++; if (dwb_wre !== 1'b1) begin errors++; $display("FAIL bst_wre got %b exp 1", dwb_wre); end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    checks++; if (dstall !== 1'b0) begin errors++; $display("FAIL bst_zero_wait_dstall got %b exp 0", dstall); end
    tick();
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL bst_done_stb got %b exp 0", dwb_stb); end
    $display("txn byte store adr=%h sel=%h dto=%h", dwb_adr, dwb_sel, dwb_dto);
  endtask

  task automatic test_half_load_wait();
    drive(5'h00, 3'b001, 32'h2002, 32'h0, 1'b0);
    tick();
    checks++; if (xsel !== 4'hC) begin errors++; $display("FAIL hld_xsel got %h exp c", xsel); end
    checks++; if (dwb_wre !== 1'b0) begin errors++; $display("FAIL hld_wre got %b exp 0", dwb_wre); end
    for (int i = 0; i < 3; i++) begin
      // a competing request during the stall must not disturb the bus
      drive(5'h08, 3'b010, 32'h5000 + 32'(i * 4), 32'h1234_5678, 1'b0);
      checks++; if (dstall !== 1'b1) begin errors++; $display("FAIL hld_dstall[%0d] got %b exp 1", i, dstall); end
      tick();
      checks++; if (dwb_sel !== 4'hC || dwb_adr !== 32'h2000 || dwb_stb !== 1'b1)
        begin errors++; $display("FAIL hld_hold[%0d] got sel=%h adr=%h stb=%b exp c/00002000/1", i, dwb_sel, dwb_adr, dwb_stb); end
    end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    checks++; if (dstall !== 1'b0) begin errors++; $display("FAIL hld_ack_dstall got %b exp 0", dstall); end
    tick();
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL hld_done_stb got %b exp 0", dwb_stb); end
    checks++; if (xsel !== 4'hC) begin errors++; $display("FAIL hld_done_xsel got %h exp c", xsel); end
    $display("txn half load adr=00002000 sel=c 3 wait cycles");
  endtask

  task automatic test_back_to_back();
    drive(5'h08, 3'b010, 32'h4000, 32'hDEAD_BEEF, 1'b1);
    tick();
    checks++; if (dwb_stb !== 1'b1 || dwb_adr !== 32'h4000) begin errors++; $display("FAIL b2b_first got stb=%b adr=%h exp 1/00004000", dwb_stb, dwb_adr); end
    drive(5'h08, 3'b010, 32'h4008, 32'hCAFE_F00D, 1'b1);
    checks++; if (dstall !== 1'b0) begin errors++; $display("FAIL b2b_dstall got %b exp 0", dstall); end
    tick();
    checks++; if (dwb_stb !== 1'b1 || dwb_adr !== 32'h4008) begin errors++; $display("FAIL b2b_second got stb=%b adr=%h exp 1/00004008", dwb_stb, dwb_adr); end
    checks++; if (dwb_dto !== 32'hCAFE_F00D) begin errors++; $display("FAIL b2b_dto got %h exp cafef00d", dwb_dto); end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    checks++; if (dstall !== 1'b0) begin errors++; $display("FAIL b2b_end_dstall got %b exp 0", dstall); end
    tick();
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL b2b_end_stb got %b exp 0", dwb_stb); end
    $display("txn back-to-back word stores 00004000, 00004008");
  endtask

  task automatic test_reset_busy();
    drive(5'h00, 3'b010, 32'h6000, 32'h0, 1'b0);
    tick();
    checks++; if (dwb_stb !== 1'b1) begin errors++; $display("FAIL rb_issue_stb got %b exp 1", dwb_stb); end
    #2 srst_n = 1'b0;
    model_reset();
    #1;
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL rb_async_stb got %b exp 0", dwb_stb); end
    checks++; if (dstall !== 1'b0) begin errors++; $display("FAIL rb_async_dstall got %b exp 0", dstall); end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    srst_n = 1'b1;
    tick();
    checks++; if (dwb_stb !== 1'b0 || dstall !== 1'b0) begin errors++; $display("FAIL rb_late_ack got stb=%b dstall=%b exp 0/0", dwb_stb, dstall); end
    #2 srst_n = 1'b0;
    model_reset();
    drive(5'h08, 3'b000, 32'h7001, 32'h0000_003C, 1'b0);
    srst_n = 1'b1;
    tick();
    checks++; if (dwb_stb !== 1'b1 || dwb_sel !== 4'h2 || dwb_adr !== 32'h7000)
      begin errors++; $display("FAIL rb_first_req got stb=%b sel=%h adr=%h exp 1/2/00007000", dwb_stb, dwb_sel, dwb_adr); end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    tick();
    $display("txn reset during busy, then first request after release");
  endtask

  task automatic test_misalign();
    drive(5'h00, 3'b010, 32'h3001, 32'h0, 1'b0);
    tick();
`ifdef T5_MISALIGN_TRAP_EN
    checks++; if (dmis !== 1'b1) begin errors++; $display("FAIL mis_dmis got %b exp 1", dmis); end
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL mis_stb got %b exp 0", dwb_stb); end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b0);
    tick();
    checks++; if (dmis !== 1'b0 || dwb_stb !== 1'b0) begin errors++; $display("FAIL mis_pulse got dmis=%b stb=%b exp 0/0", dmis, dwb_stb); end
`else
    checks++; if (dwb_stb !== 1'b1) begin errors++; $display("FAIL mis_stb got %b exp 1", dwb_stb); end
    checks++; if (dwb_sel !== 4'hF || dwb_adr !== 32'h3000) begin errors++; $display("FAIL mis_lane got sel=%h adr=%h exp f/00003000", dwb_sel, dwb_adr); end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    tick();
    checks++; if (dwb_stb !== 1'b0) begin errors++; $display("FAIL mis_done_stb got %b exp 0", dwb_stb); end
`endif
    $display("txn misaligned word load 00003001");
  endtask

  task automatic test_non_mem();
    drive(5'h00, 3'b100, 32'h0011, 32'h0, 1'b0);
    tick();
    checks++; if (xsel !== 4'h2) begin errors++; $display("FAIL nm_setup_xsel got %h exp 2", xsel); end
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b1);
    tick();
    drive(5'h00, 3'b011, 32'h0008, 32'h0, 1'b0);
    tick();
    checks++; if (dwb_stb !== 1'b0 || xsel !== 4'h2) begin errors++; $display("FAIL nm_rsvd got stb=%b xsel=%h exp 0/2", dwb_stb, xsel); end
    drive(5'h0C, 3'b010, 32'h0004, 32'h0, 1'b0);
    tick();
    checks++; if (dwb_stb !== 1'b0 || xsel !== 4'h2) begin errors++; $display("FAIL nm_alu got stb=%b xsel=%h exp 0/2", dwb_stb, xsel); end
    $display("txn reserved-size load and ALU op, no strobe");
  endtask

  task automatic test_random();
    logic [4:0] opc;
    #2 srst_n = 1'b0;
    model_reset();
    drive(5'h04, 3'b000, 32'h0, 32'h0, 1'b0);
    srst_n = 1'b1;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0:       opc = 5'h00;
        1:       opc = 5'h08;
        2:       opc = 5'h04;
        default: opc = 5'($urandom);
      endcase
      drive(opc, 3'($urandom), $urandom, $urandom, ($urandom_range(0, 2) != 0));
      checks++; if (dstall !== (m_busy && !dwb_ack)) begin errors++; $display("FAIL rnd_dstall[%0d] got %b exp %b", i, dstall, m_busy && !dwb_ack); end
      tick();
      checks++; if (dwb_stb !== m_busy) begin errors++; $display("FAIL rnd_stb[%0d] got %b exp %b", i, dwb_stb, m_busy); end
      checks++; if (dwb_adr !== m_adr || dwb_sel !== m_sel || dwb_dto !== m_dto || dwb_wre !== m_wre)
        begin errors++; $display("FAIL rnd_bus[%0d] got adr=%h sel=%h dto=%h wre=%b exp %h/%h/%h/%b", i, dwb_adr, dwb_sel, dwb_dto, dwb_wre, m_adr, m_sel, m_dto, m_wre); end
      checks++; if (xsel !== m_xsel) begin errors++; $display("FAIL rnd_xsel[%0d] got %h exp %h", i, xsel, m_xsel); end
`ifdef T5_MISALIGN_TRAP_EN
      checks++; if (dmis !== m_dmis) begin errors++; $display("FAIL rnd_dmis[%0d] got %b exp %b", i, dmis, m_dmis); end
`endif
    end
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_byte_store();
    test_half_load_wait();
    test_back_to_back();
    test_reset_busy();
    test_misalign();
    test_non_mem();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
